// File: rtl/ones_count_sequencer.sv
// ones_count_sequencer
//   Samples a switch vector and counts its set bits, one bit per clock.
//   It then splits the count into two BCD digits by repeated subtraction of 10.
//   The digits are registered and change only when a conversion completes.
//
// Ports
//   i_clk    : clock, all registers update on the rising edge
//   i_rst_n  : synchronous active-low reset
//   i_sw     : switch vector, captured once per conversion
//   i_start  : level request, sampled only while idle
//   o_busy   : high whenever a conversion is in progress
//   o_done   : one-cycle pulse after the final (DONE) edge
//   o_dig0   : units digit, 0..9
//   o_dig1   : tens digit, 0..9
//
// Optional build macro
//   ONES_SEQ_AUTO_EN : while idle, also start a conversion when i_sw differs from
//                      the vector captured by the previous conversion.
module ones_count_sequencer #(
   parameter int unsigned N = 10
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [N-1:0] i_sw,
   input  logic         i_start,
   output logic         o_busy,
   output logic         o_done,
   output logic [3:0]   o_dig0,
   output logic [3:0]   o_dig1
);

   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(N - 1);

   typedef enum logic [1:0] {StIdle, StCount, StDiv, StDone} state_e;

   state_e          r_state;
   state_e          w_state_next;
   logic [N-1:0]    r_shreg;
   logic [CntW-1:0] r_bitcnt;
   logic [6:0]      r_rem;
   logic [3:0]      r_tens;
   logic [3:0]      r_dig0;
   logic [3:0]      r_dig1;
   logic            r_done;
   logic            w_go;

`ifdef ONES_SEQ_AUTO_EN
   logic [N-1:0] r_last_sw;

   assign w_go = i_start | (i_sw != r_last_sw);

   // Remember the vector of the conversion being started so the display
   // only re-converts when the switches actually move.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_last_sw <= '0;
      end else if ((r_state == StIdle) && w_go) begin
         r_last_sw <= i_sw;
      end
   end
`else
   assign w_go = i_start;
`endif

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_go) w_state_next = StCount;
         StCount: if (r_bitcnt == LastBit) w_state_next = StDiv;
         StDiv:   if (r_rem < 7'd10) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Datapath
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_shreg  <= '0;
         r_bitcnt <= '0;
         r_rem    <= '0;
         r_tens   <= '0;
         r_dig0   <= '0;
         r_dig1   <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_go) begin
                  r_shreg  <= i_sw;
                  r_rem    <= '0;
                  r_tens   <= '0;
                  r_bitcnt <= '0;
               end
            end
            StCount: begin
               r_rem    <= r_rem + 7'(r_shreg[0]);
               r_shreg  <= r_shreg >> 1;
               r_bitcnt <= r_bitcnt + CntW'(1);
            end
            StDiv: begin
               if (r_rem >= 7'd10) begin
                  r_rem  <= r_rem - 7'd10;
                  r_tens <= r_tens + 4'd1;
               end
            end
            StDone: begin
               r_dig0 <= r_rem[3:0];
               r_dig1 <= r_tens;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_busy = (r_state != StIdle);
   assign o_done = r_done;
   assign o_dig0 = r_dig0;
   assign o_dig1 = r_dig1;

endmodule
